// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice reused per bit,
// LSB first, with start/ready handshake and a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cff;
    logic             s;
    logic             co;
    logic             last;

    assign s    = op_a[0] ^ op_b[0] ^ cff;
    assign co   = (op_a[0] & op_b[0]) | (op_a[0] & cff) | (op_b[0] & cff);
    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            cff      <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                // subtraction is a + ~b + 1; the +1 enters as the initial carry
                op_a     <= a;
                op_b     <= sub ? ~b : b;
                cff      <= sub;
                cnt      <= '0;
                sum      <= '0;
                carry    <= 1'b0;
                overflow <= 1'b0;
            end
        end else if (state == RUN) begin
            sum  <= {s, sum[WIDTH-1:1]};
            op_a <= op_a >> 1;
            op_b <= op_b >> 1;
            cff  <= co;
            if (last) begin
                cnt      <= '0;
                carry    <= co;
                overflow <= cff ^ co;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract controller that time-shares one full-adder slice (sum = x^y^cin, cout = majority(x,y,cin)) across a WIDTH-bit operation, one bit per clock, LSB first.
- Captures operands on a start/ready handshake, sequences the slice with a carry flip-flop and bit counter, and presents the result with a one-cycle done pulse.
- Serves as the area-cheap arithmetic unit for multi-bit datapaths built on the full-adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; qualified by ready.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high only in IDLE; start is accepted only when ready=1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- sum  output  WIDTH  result register.
- carry  output  1  final carry out of MSB (for subtract: 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: rst=1 at an edge forces state IDLE, bit counter 0, carry FF 0, operand shift registers 0, sum=0, carry=0, overflow=0, done=0, busy=0. ready=1 from the following cycle. rst has priority over every other input, including mid-RUN; a partial operation is discarded and no done is produced.
- States: IDLE (ready=1), RUN (busy=1), DONE (done=1). Outputs are decoded from registered state only, so they are glitch-free.
- Transitions:
  - IDLE -> RUN at an edge with start=1.
  - RUN -> RUN while cnt < WIDTH-1.
  - RUN -> DONE at the edge where cnt = WIDTH-1.
  - DONE -> IDLE unconditionally.
- Acceptance edge E0 (IDLE, start=1):
  - Latch opA=a.
  - Latch opB = b when sub=0, or ~b when sub=1.
  - Carry FF = sub; cnt=0.
  - Clear sum, carry and overflow to 0.
- Each RUN edge E1..EWIDTH: slice inputs are opA[0], opB[0] and the carry FF.
  - Slice sum bit shifts into sum from the MSB end (sum <= {s, sum[WIDTH-1:1]}).
  - opA and opB shift right one bit; carry FF <= cout; cnt increments.
- At edge EWIDTH (the MSB step):
  - carry <= cout.
  - overflow <= carry-FF value (carry into MSB) XOR cout.
- Latency and output timing:
  - done is high in the single cycle between edges EWIDTH and EWIDTH+1; sum, carry and overflow are final from that cycle.
  - Results hold until the next acceptance edge or reset.
- Handshake:
  - start while busy or in DONE is ignored (not queued).
  - start held high continuously yields one op per WIDTH+2 cycles (minimum one IDLE cycle between ops).
- Operand isolation: changes on a, b or sub after E0 have no effect on the in-flight operation.
- Arithmetic is modulo 2^WIDTH. sum width is exactly WIDTH; carry and overflow are the only indication of range exceed.
- Wrap: cnt never exceeds WIDTH-1; there is no counter wrap in RUN.

Test Plan (WIDTH=8):
1. Reset, then start with a=8'h05, b=8'h03, sub=0 -> ready drops after E0; done pulses exactly 8 edges after E0; sum=8'h08, carry=0, overflow=0.
2. Add boundary cases:
   - a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, carry=1, overflow=0.
   - a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, carry=0, overflow=1.
3. Subtract cases:
   - a=8'h05, b=8'h03, sub=1 -> sum=8'h02, carry=1, overflow=0.
   - a=8'h03, b=8'h05, sub=1 -> sum=8'hFE, carry=0, overflow=0.
   - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, carry=1, overflow=1.
4. Start with a=8'h10, b=8'h20. On the cycle after E0, change a to 8'hFF, b to 8'hFF, sub to 1, and pulse start -> second start is ignored; result is 8'h30 with carry=0, and only one done pulse occurs.
5. Assert rst at the 4th RUN edge -> next cycle: sum=0, carry=0, overflow=0, done=0, ready=1; no done pulse follows. A subsequent op (8'h01+8'h01) gives 8'h02.
6. Hold start=1 permanently with random a, b, sub for 200 ops:
   - done period is exactly 10 cycles.
   - Every result matches a reference model of (a ± b) mod 256, with matching carry and overflow.
